// File: rtl/simplez_loader_if.sv
// simplez_loader_if -- byte/bus bundle between the serial program loader,
// the UART pair and the Simplez RAM write port.
//
// Signals:
//   rx_data  [7:0]  byte from uart_rx, valid while rx_rcv=1
//   rx_rcv          one-cycle byte-received strobe
//   tx_ready        uart_tx idle
//   tx_data  [7:0]  acknowledge byte to uart_tx
//   tx_start        one-cycle transmit strobe
//   mem_addr [8:0]  RAM write address
//   mem_din  [11:0] RAM write data
//   mem_we          one-cycle RAM write strobe
//
// Modports:
//   master  -- environment side (drives the UART receive/ready signals)
//   slave   -- loader side (drives the acknowledge and RAM write port)
interface simplez_loader_if;
    logic [7:0]  rx_data;
    logic        rx_rcv;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic [8:0]  mem_addr;
    logic [11:0] mem_din;
    logic        mem_we;

    modport master (
        output rx_data, rx_rcv, tx_ready,
        input  tx_data, tx_start, mem_addr, mem_din, mem_we
    );

    modport slave (
        input  rx_data, rx_rcv, tx_ready,
        output tx_data, tx_start, mem_addr, mem_din, mem_we
    );
endinterface

// File: rtl/simplez_loader.sv
// simplez_loader -- serial program loader in front of the Simplez core.
//
// Receives a framed program image byte-by-byte from uart_rx, writes the
// 12-bit words into the core's 512x12 RAM, answers with a one-byte
// acknowledge through uart_tx and releases the CPU reset only after a
// successful load. Once released (RUN) the loader ignores rx until rstn.
//
// Frame: SYNC, CNT_H (bit0 = count[8]), CNT_L, count x {WH[3:0], WL}, [CHK]
//
// Optional feature: define SIMPLEZ_LOADER_CHECKSUM_EN to expect and verify
// a trailing modulo-256 sum of CNT_H, CNT_L and all word bytes.
//
// Ports:
//   clk       system clock
//   rstn      synchronous active-low reset
//   bus       simplez_loader_if.slave (UART rx/tx + RAM write port)
//   cpu_rstn  CPU reset, active-low; high only in RUN
//   busy      frame in progress
//   err       sticky error of the last frame, cleared by the next SYNC byte
module simplez_loader #(
    parameter int unsigned MAX_WORDS = 504,
    parameter logic [7:0]  SYNC_BYTE = 8'h4C,
    parameter logic [7:0]  ACK_OK    = 8'h4B,
    parameter logic [7:0]  ACK_ERR   = 8'h45
) (
    input  logic            clk,
    input  logic            rstn,
    simplez_loader_if.slave bus,
    output logic            cpu_rstn,
    output logic            busy,
    output logic            err
);
    typedef enum logic [3:0] {
        S_IDLE, S_CNT_H, S_CNT_L, S_WH, S_WL, S_WRITE, S_CHK, S_ACK, S_RUN
    } state_t;

    localparam logic [8:0] MAX_CNT = 9'(MAX_WORDS);

`ifdef SIMPLEZ_LOADER_CHECKSUM_EN
    localparam state_t FRAME_END = S_CHK;
`else
    localparam state_t FRAME_END = S_ACK;
`endif

    state_t      state_q, state_d;
    logic [8:0]  count_q, count_d;
    logic [8:0]  mem_addr_q, mem_addr_d;
    logic [11:0] mem_din_q, mem_din_d;
    logic [3:0]  wh_q, wh_d;
    logic        mem_we_q, mem_we_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        cpu_rstn_q, cpu_rstn_d;
    logic        tx_start;
    logic [8:0]  rx_count;
    logic [8:0]  addr_inc;
    logic        chk_bad;

    // Full word count as it stands once CNT_L arrives.
    assign rx_count = {count_q[8], bus.rx_data};
    // Words are written to consecutive addresses starting at 0, so the
    // write address doubles as the count of words already stored.
    assign addr_inc = mem_addr_q + 9'd1;

`ifdef SIMPLEZ_LOADER_CHECKSUM_EN
    logic [7:0] chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if (state_q == S_IDLE) begin
            chk_d = '0;
        end else if (bus.rx_rcv &&
                     (state_q inside {S_CNT_H, S_CNT_L, S_WH, S_WL})) begin
            chk_d = chk_q + bus.rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) chk_q <= '0;
        else       chk_q <= chk_d;
    end

    assign chk_bad = (bus.rx_data != chk_q);
`else
    assign chk_bad = 1'b0;
`endif

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        count_d    = count_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        wh_d       = wh_q;
        mem_we_d   = 1'b0;
        err_d      = err_q;
        busy_d     = busy_q;
        tx_data_d  = tx_data_q;
        tx_start   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.rx_rcv && bus.rx_data == SYNC_BYTE) begin
                    busy_d     = 1'b1;
                    err_d      = 1'b0;
                    mem_addr_d = '0;
                    state_d    = S_CNT_H;
                end
            end
            S_CNT_H: begin
                if (bus.rx_rcv) begin
                    count_d = {bus.rx_data[0], 8'h00};
                    state_d = S_CNT_L;
                end
            end
            S_CNT_L: begin
                if (bus.rx_rcv) begin
                    count_d = rx_count;
                    if (rx_count > MAX_CNT) begin
                        err_d   = 1'b1;
                        state_d = S_ACK;
                    end else if (rx_count == '0) begin
                        state_d = FRAME_END;
                    end else begin
                        state_d = S_WH;
                    end
                end
            end
            S_WH: begin
                if (bus.rx_rcv) begin
                    wh_d    = bus.rx_data[3:0];
                    state_d = S_WL;
                end
            end
            S_WL: begin
                if (bus.rx_rcv) begin
                    mem_din_d = {wh_q, bus.rx_data};
                    mem_we_d  = 1'b1;
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                // mem_we is high this cycle with the address still stable;
                // the address moves on at the end of it.
                mem_addr_d = addr_inc;
                state_d    = (addr_inc == count_q) ? FRAME_END : S_WH;
            end
            S_CHK: begin
                if (bus.rx_rcv) begin
                    if (chk_bad) err_d = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (bus.tx_ready) begin
                    tx_start = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = err_q ? S_IDLE : S_RUN;
                end
            end
            S_RUN: begin
                // Keyboard owns rx from here on; only rstn leaves RUN.
            end
            default: state_d = S_IDLE;
        endcase

        // The acknowledge byte is fixed on entry to ACK so it is already
        // valid in the cycle tx_start fires.
        if (state_d == S_ACK && state_q != S_ACK) begin
            tx_data_d = err_d ? ACK_ERR : ACK_OK;
        end
    end

    // CPU reset is released from a flop so it cannot glitch.
    assign cpu_rstn_d = (state_d == S_RUN);

    // NOTE: rstn is sampled on the clock edge (synchronous reset) and all
    // state updates use non-blocking assignments so every flop samples the
    // values from before the edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            wh_q       <= '0;
            mem_we_q   <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            tx_data_q  <= '0;
            cpu_rstn_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            wh_q       <= wh_d;
            mem_we_q   <= mem_we_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            tx_data_q  <= tx_data_d;
            cpu_rstn_q <= cpu_rstn_d;
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
    assign bus.mem_we   = mem_we_q;
    assign cpu_rstn     = cpu_rstn_q;
    assign busy         = busy_q;
    assign err          = err_q;
endmodule

// File: tb/tb_simplez_loader.sv
// tb_simplez_loader -- self-checking bench for simplez_loader.
//
// Directed frames from the test plan plus randomized frames. Expected RAM
// writes and acknowledge bytes come from a frame parser working on the list
// of bytes sent since the last reset; a monitor logs what the DUT does.
module tb_simplez_loader;
    localparam logic [7:0] SYNC = 8'h4C;
    localparam logic [7:0] OK   = 8'h4B;
    localparam logic [7:0] ERR  = 8'h45;
`ifdef SIMPLEZ_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic cpu_rstn, busy, err;

    simplez_loader_if bus();

    simplez_loader dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus),
        .cpu_rstn (cpu_rstn),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  sent[$];
    logic [7:0]  frame[$];
    logic [20:0] wr_log[$];
    logic [20:0] exp_wr[$];
    logic [7:0]  tx_log[$];
    logic [7:0]  exp_tx[$];
    bit          exp_run;
    bit          exp_err;
    int          cycle    = 0;
    int          tx_cyc   = -1;
    int          rise_cyc = -1;
    logic        cpu_prev = 1'b0;

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rstn) begin
            wr_log.delete();
            tx_log.delete();
            tx_cyc   <= -1;
            rise_cyc <= -1;
        end else begin
            if (bus.mem_we) wr_log.push_back({bus.mem_addr, bus.mem_din});
            if (bus.tx_start) begin
                tx_log.push_back(bus.tx_data);
                tx_cyc <= cycle;
            end
            if (cpu_rstn && !cpu_prev && rise_cyc < 0) rise_cyc <= cycle;
        end
        cpu_prev <= cpu_rstn;
        cycle    <= cycle + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: parse the byte stream since reset the way a host would
    // describe the protocol, producing writes, acks and final status.
    function automatic void run_model();
        int         i;
        int         n;
        logic [7:0] sum;
        bit         bad;
        i = 0;
        exp_wr.delete();
        exp_tx.delete();
        exp_run = 1'b0;
        exp_err = 1'b0;
        while (i < sent.size() && !exp_run) begin
            if (sent[i] != SYNC) begin
                i++;
                continue;
            end
            i++;
            exp_err = 1'b0;
            if (i + 2 > sent.size()) return;
            n   = int'(sent[i][0]) * 256 + int'(sent[i+1]);
            sum = 8'(sent[i] + sent[i+1]);
            i  += 2;
            if (n > 504) begin
                exp_err = 1'b1;
                exp_tx.push_back(ERR);
                continue;
            end
            for (int w = 0; w < n; w++) begin
                if (i + 2 > sent.size()) return;
                exp_wr.push_back({w[8:0], sent[i][3:0], sent[i+1]});
                sum = 8'(sum + sent[i] + sent[i+1]);
                i  += 2;
            end
            bad = 1'b0;
            if (CHK_EN) begin
                if (i >= sent.size()) return;
                bad = (sent[i] != sum);
                i++;
            end
            exp_err = bad;
            exp_tx.push_back(bad ? ERR : OK);
            exp_run = !bad;
        end
    endfunction

    task automatic send(input logic [7:0] b);
        sent.push_back(b);
        @(posedge clk); #1;
        bus.rx_data = b;
        bus.rx_rcv  = 1'b1;
        @(posedge clk); #1;
        bus.rx_rcv  = 1'b0;
        bus.rx_data = 8'h00;
        repeat (3) @(posedge clk);
    endtask

    task automatic send_frame();
        foreach (frame[i]) send(frame[i]);
    endtask

    // Random frame of n words; trailing sum byte always appended (ignored
    // in RUN when the checksum feature is off), optionally corrupted.
    function automatic void build_frame(input int n, input bit corrupt);
        logic [7:0] b, sum;
        frame.delete();
        frame.push_back(SYNC);
        b = {7'($urandom), 1'(n >> 8)};
        frame.push_back(b);
        sum = b;
        b = 8'(n);
        frame.push_back(b);
        sum = 8'(sum + b);
        for (int w = 0; w < 2 * n; w++) begin
            b = 8'($urandom);
            frame.push_back(b);
            sum = 8'(sum + b);
        end
        frame.push_back(corrupt ? (sum ^ 8'h5A) : sum);
    endfunction

    task automatic check_cleared(input string tag);
        check({tag, ".tx_data"},  32'(bus.tx_data),  32'h0);
        check({tag, ".tx_start"}, 32'(bus.tx_start), 32'h0);
        check({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'h0);
        check({tag, ".mem_din"},  32'(bus.mem_din),  32'h0);
        check({tag, ".mem_we"},   32'(bus.mem_we),   32'h0);
        check({tag, ".cpu_rstn"}, 32'(cpu_rstn),     32'h0);
        check({tag, ".busy"},     32'(busy),         32'h0);
        check({tag, ".err"},      32'(err),          32'h0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_cleared(tag);
        @(posedge clk); #1;
        rstn = 1'b1;
        sent.delete();
    endtask

    task automatic verify(input string tag);
        run_model();
        for (int k = 0; k < 3000 && tx_log.size() < exp_tx.size(); k++)
            @(negedge clk);
        repeat (4) @(negedge clk);
        check({tag, ".ack_count"}, 32'(tx_log.size()), 32'(exp_tx.size()));
        foreach (exp_tx[i])
            check($sformatf("%s.ack%0d", tag, i),
                  (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hxxxxxxxx,
                  32'(exp_tx[i]));
        check({tag, ".wr_count"}, 32'(wr_log.size()), 32'(exp_wr.size()));
        foreach (exp_wr[i])
            check($sformatf("%s.wr%0d", tag, i),
                  (i < wr_log.size()) ? 32'(wr_log[i]) : 32'hxxxxxxxx,
                  32'(exp_wr[i]));
        check({tag, ".err"},      32'(err),      32'(exp_err));
        check({tag, ".busy"},     32'(busy),     32'h0);
        check({tag, ".cpu_rstn"}, 32'(cpu_rstn), 32'(exp_run));
        if (exp_run)
            check({tag, ".rise_lat"}, 32'(rise_cyc - tx_cyc), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_rcv   = 1'b0;
        bus.tx_ready = 1'b1;

        do_reset("reset");

        // Basic two-word load, plus busy mid-frame.
        frame = '{8'h4C, 8'h00, 8'h02, 8'h0A, 8'h05};
        send_frame();
        check("load1.busy_mid", 32'(busy), 32'h1);
        frame = '{8'h01, 8'hFF, 8'h11};
        send_frame();
        verify("load1");

        // Bad checksum, then a correct resend.
        do_reset("rst2");
        frame = '{8'h4C, 8'h00, 8'h02, 8'h0A, 8'h05, 8'h01, 8'hFF, 8'h12};
        send_frame();
        verify("badchk");
        frame = '{8'h4C, 8'h00, 8'h02, 8'h0A, 8'h05, 8'h01, 8'hFF, 8'h11};
        send_frame();
        verify("resend");

        // Count 505 is rejected immediately.
        do_reset("rst3");
        frame = '{8'h4C, 8'h01, 8'hF9};
        send_frame();
        verify("cnt505");

        // Garbage then an empty frame.
        do_reset("rst4");
        frame = '{8'h00, 8'h41, 8'h4C, 8'h00, 8'h00, 8'h00};
        send_frame();
        verify("empty");

        // Acknowledge held off by tx_ready.
        do_reset("rst5");
        bus.tx_ready = 1'b0;
        build_frame(3, 1'b0);
        send_frame();
        repeat (100) @(negedge clk);
        check("txwait.no_start", 32'(tx_log.size()), 32'h0);
        check("txwait.busy",     32'(busy),          32'h1);
        bus.tx_ready = 1'b1;
        verify("txwait");

        // Reset after the first word of a two-word frame.
        do_reset("rst6");
        frame = '{8'h4C, 8'h00, 8'h02, 8'h3C, 8'hA5};
        send_frame();
        run_model();
        repeat (3) @(negedge clk);
        check("mid.wr_count", 32'(wr_log.size()), 32'(exp_wr.size()));
        do_reset("midrst");
        build_frame(2, 1'b0);
        send_frame();
        verify("after_mid");

        // Largest accepted frame.
        do_reset("rst7");
        build_frame(504, 1'b0);
        send_frame();
        verify("max504");

        // Randomized frames with garbage prefix and random checksum faults.
        for (int it = 0; it < 5; it++) begin
            logic [7:0] g;
            do_reset($sformatf("rrst%0d", it));
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                g = 8'($urandom);
                if (g == SYNC) g = 8'h00;
                send(g);
            end
            build_frame(int'($urandom_range(1, 6)), 1'($urandom));
            send_frame();
            verify($sformatf("rand%0d", it));
        end

        do_reset("final");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
